// File: rtl/fifo_pkg.sv
// fifo_pkg
//   Constants and types shared by the synchronous FIFO and the blocks that
//   drain it.
//   FIFO_WIDTH  : width of one FIFO word
//   FIFO_DEPTH  : number of FIFO entries
//   OUT_WIDTH   : width of a packed pair of FIFO words
//   asm_state_t : pair-assembly state of the read packer
package fifo_pkg;

    localparam int FIFO_WIDTH = 16;
    localparam int FIFO_DEPTH = 8;
    localparam int OUT_WIDTH  = 2 * FIFO_WIDTH;

    typedef enum logic [0:0] {
        A_EMPTY = 1'b0,   // no half waiting in lo_q
        A_HALF  = 1'b1    // lo_q holds the first half of a pair
    } asm_state_t;

endpackage

// File: rtl/fifo_read_packer.sv
// fifo_read_packer
//   Drains a synchronous FIFO one word per pop and packs consecutive pairs
//   into double-width words on a valid/ready output. Pops are credit-limited
//   against the three half-word slots (lo_q plus the two-half output
//   register), so a popped word always has a slot to land in. A flush emits a
//   trailing odd half zero-padded in the upper half.
//
//   Ports
//     clk, rst_n      : clock, asynchronous active-low reset
//     fifo_rd_en      : pop request to the FIFO (combinational)
//     fifo_data_out   : FIFO read data, valid the cycle after a pop
//     fifo_empty      : FIFO empty flag
//     fifo_underflow  : FIFO underflow flag
//     flush           : one-cycle pulse, emit any pending odd half
//     m_data          : packed word, first-popped word in the low half
//     m_valid         : m_data valid
//     m_odd           : upper half of m_data is padding
//     m_ready         : consumer ready
//     flush_done      : one-cycle pulse when a flush completes
//     err_underflow   : sticky underflow indication
//     words_out       : count of accepted output words (wraps)
module fifo_read_packer #(
    parameter int FIFO_WIDTH = fifo_pkg::FIFO_WIDTH,
    parameter int OUT_WIDTH  = 2 * FIFO_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  fifo_rd_en,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    input  logic                  flush,
    output logic [OUT_WIDTH-1:0]  m_data,
    output logic                  m_valid,
    output logic                  m_odd,
    input  logic                  m_ready,
    output logic                  flush_done,
    output logic                  err_underflow,
    output logic [15:0]           words_out
);

    import fifo_pkg::*;

    asm_state_t            state_q,      state_d;
    logic [FIFO_WIDTH-1:0] lo_q,         lo_d;
    logic                  lo_valid_q,   lo_valid_d;
    logic [OUT_WIDTH-1:0]  m_data_q,     m_data_d;
    logic                  m_valid_q,    m_valid_d;
    logic                  m_odd_q,      m_odd_d;
    logic                  inflight_q,   inflight_d;
    logic                  flush_pend_q, flush_pend_d;
    logic                  flush_done_q, flush_done_d;
    logic                  err_q,        err_d;
    logic [15:0]           words_q,      words_d;

    logic       accept;
    logic       pend_eff;
    logic       flush_complete;
    logic [2:0] slots_used;

    assign accept = m_valid_q && m_ready;

    // Halves already held plus the one on its way; an accept this cycle
    // frees the two output halves.
    assign slots_used = {1'b0, m_valid_q, lo_valid_q} + {2'b00, inflight_q};

    // Gated with rst_n so no pop is requested while the FIFO is in reset.
    assign fifo_rd_en = rst_n && !fifo_empty && !flush_pend_q &&
                        ((slots_used - {1'b0, accept, 1'b0}) < 3'd3);

    // A flush arriving this cycle is acted on at once when nothing stands in
    // the way; otherwise it is remembered in flush_pend_q.
    assign pend_eff = flush_pend_q || flush;

    always_comb begin
        state_d        = state_q;
        lo_d           = lo_q;
        lo_valid_d     = lo_valid_q;
        m_data_d       = m_data_q;
        m_valid_d      = m_valid_q;
        m_odd_d        = m_odd_q;
        flush_done_d   = 1'b0;
        flush_complete = 1'b0;
        inflight_d     = fifo_rd_en;
        err_d          = err_q || fifo_underflow;
        words_d        = words_q + {15'd0, accept};

        if (accept) begin
            m_valid_d = 1'b0;
        end

        if (inflight_q) begin
            // Landing half takes priority; the credit rule guarantees the
            // output register is free or being accepted when a pair closes.
            case (state_q)
                A_EMPTY: begin
                    lo_d       = fifo_data_out;
                    lo_valid_d = 1'b1;
                    state_d    = A_HALF;
                end
                A_HALF: begin
                    m_data_d   = {fifo_data_out, lo_q};
                    m_valid_d  = 1'b1;
                    m_odd_d    = 1'b0;
                    lo_valid_d = 1'b0;
                    state_d    = A_EMPTY;
                end
                default: state_d = A_EMPTY;
            endcase
        end else if (pend_eff) begin
            case (state_q)
                A_HALF: begin
                    if (!m_valid_q || accept) begin
                        m_data_d       = {{FIFO_WIDTH{1'b0}}, lo_q};
                        m_valid_d      = 1'b1;
                        m_odd_d        = 1'b1;
                        lo_valid_d     = 1'b0;
                        state_d        = A_EMPTY;
                        flush_done_d   = 1'b1;
                        flush_complete = 1'b1;
                    end
                end
                default: begin
                    flush_done_d   = 1'b1;
                    flush_complete = 1'b1;
                end
            endcase
        end

        flush_pend_d = pend_eff && !flush_complete;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= A_EMPTY;
            lo_q         <= '0;
            lo_valid_q   <= 1'b0;
            m_data_q     <= '0;
            m_valid_q    <= 1'b0;
            m_odd_q      <= 1'b0;
            inflight_q   <= 1'b0;
            flush_pend_q <= 1'b0;
            flush_done_q <= 1'b0;
            err_q        <= 1'b0;
            words_q      <= '0;
        end else begin
            state_q      <= state_d;
            lo_q         <= lo_d;
            lo_valid_q   <= lo_valid_d;
            m_data_q     <= m_data_d;
            m_valid_q    <= m_valid_d;
            m_odd_q      <= m_odd_d;
            inflight_q   <= inflight_d;
            flush_pend_q <= flush_pend_d;
            flush_done_q <= flush_done_d;
            err_q        <= err_d;
            words_q      <= words_d;
        end
    end

    assign m_data        = m_data_q;
    assign m_valid       = m_valid_q;
    assign m_odd         = m_odd_q;
    assign flush_done    = flush_done_q;
    assign err_underflow = err_q;
    assign words_out     = words_q;

endmodule

// File: tb/tb_fifo_read_packer.sv
// tb_fifo_read_packer
//   Directed bench for fifo_read_packer with a small behavioural FIFO read
//   port: data appears the cycle after a pop, empty follows the occupancy.
module tb_fifo_read_packer;

    logic        clk;
    logic        rst_n;
    logic        fifo_rd_en;
    logic [15:0] fifo_data_out;
    logic        fifo_empty;
    logic        fifo_underflow;
    logic        flush;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_odd;
    logic        m_ready;
    logic        flush_done;
    logic        err_underflow;
    logic [15:0] words_out;

    int errors = 0;
    int checks = 0;

    // behavioural FIFO
    logic [15:0] mem [0:63];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic        under_q;
    logic        uf_inj;

    assign fifo_empty     = (wr_ptr == rd_ptr);
    assign fifo_underflow = under_q | uf_inj;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_data_out <= '0;
            under_q       <= 1'b0;
        end else begin
            under_q <= 1'b0;
            if (fifo_rd_en) begin
                if (wr_ptr == rd_ptr) begin
                    under_q <= 1'b1;
                end else begin
                    fifo_data_out <= mem[rd_ptr];
                    rd_ptr        <= rd_ptr + 1;
                end
            end
        end
    end

    // output / event monitor
    int          pop_cnt = 0;
    int          fd_cnt  = 0;
    int          out_cnt = 0;
    logic [31:0] out_data [0:63];
    logic        out_odd  [0:63];

    always @(posedge clk) begin
        if (rst_n) begin
            if (fifo_rd_en) pop_cnt <= pop_cnt + 1;
            if (flush_done) fd_cnt <= fd_cnt + 1;
            if (m_valid && m_ready) begin
                out_data[out_cnt] <= m_data;
                out_odd[out_cnt]  <= m_odd;
                out_cnt           <= out_cnt + 1;
            end
        end
    end

    fifo_read_packer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_data_out (fifo_data_out),
        .fifo_empty    (fifo_empty),
        .fifo_underflow(fifo_underflow),
        .flush         (flush),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_odd         (m_odd),
        .m_ready       (m_ready),
        .flush_done    (flush_done),
        .err_underflow (err_underflow),
        .words_out     (words_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] v);
        mem[wr_ptr] = v;
        wr_ptr      = wr_ptr + 1;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    int pop_base;
    int fd_base;

    initial begin
        rst_n   = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b1;
        uf_inj  = 1'b0;

        // reset with data waiting in the FIFO
        push(16'h1111); push(16'h2222); push(16'h3333); push(16'h4444);
        step(); step();
        chk("rst_rd_en",   {31'd0, fifo_rd_en},    32'd0);
        chk("rst_m_valid", {31'd0, m_valid},       32'd0);
        chk("rst_m_data",  m_data,                 32'd0);
        chk("rst_m_odd",   {31'd0, m_odd},         32'd0);
        chk("rst_fdone",   {31'd0, flush_done},    32'd0);
        chk("rst_err",     {31'd0, err_underflow}, 32'd0);
        chk("rst_words",   {16'd0, words_out},     32'd0);

        // streaming: four consecutive pops, pairs out with m_ready=1
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("str_pop0", {31'd0, fifo_rd_en}, 32'd1);
        step();
        chk("str_pop1", {31'd0, fifo_rd_en}, 32'd1);
        chk("str_nv1",  {31'd0, m_valid},    32'd0);
        step();
        chk("str_pop2", {31'd0, fifo_rd_en}, 32'd1);
        chk("str_nv2",  {31'd0, m_valid},    32'd0);
        step();
        chk("str_pop3", {31'd0, fifo_rd_en}, 32'd1);
        chk("str_v3",   {31'd0, m_valid},    32'd1);
        chk("str_d0",   m_data,              32'h2222_1111);
        step();
        chk("str_nopop", {31'd0, fifo_rd_en}, 32'd0);
        chk("str_nv4",   {31'd0, m_valid},    32'd0);
        step();
        chk("str_v5",   {31'd0, m_valid}, 32'd1);
        chk("str_d1",   m_data,           32'h4444_3333);
        chk("str_odd1", {31'd0, m_odd},   32'd0);
        step();
        chk("str_words", {16'd0, words_out}, 32'd2);
        chk("str_pops",  pop_cnt,            32'd4);

        // backpressure: eight words waiting, consumer stalled
        m_ready  = 1'b0;
        pop_base = pop_cnt;
        for (int k = 0; k < 8; k++) push(16'hB000 + 16'(k));
        for (int k = 0; k < 10; k++) step();
        chk("bp_pops",  pop_cnt - pop_base,  32'd3);
        chk("bp_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        chk("bp_valid", {31'd0, m_valid},    32'd1);
        chk("bp_hold0", m_data,              32'hB001_B000);
        step();
        chk("bp_hold1", m_data,              32'hB001_B000);
        m_ready = 1'b1;
        for (int k = 0; k < 30; k++) step();
        chk("bp_outs",  out_cnt,             32'd6);
        chk("bp_out0",  out_data[2],         32'hB001_B000);
        chk("bp_out1",  out_data[3],         32'hB003_B002);
        chk("bp_out2",  out_data[4],         32'hB005_B004);
        chk("bp_out3",  out_data[5],         32'hB007_B006);
        chk("bp_odd3",  {31'd0, out_odd[5]}, 32'd0);
        chk("bp_words", {16'd0, words_out},  32'd6);
        chk("bp_allpops", pop_cnt - pop_base, 32'd8);

        // odd flush: three words, then flush the trailing half
        push(16'h000A); push(16'h000B); push(16'h000C);
        for (int k = 0; k < 8; k++) step();
        pop_base = pop_cnt;
        fd_base  = fd_cnt;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("fl_valid", {31'd0, m_valid},    32'd1);
        chk("fl_data",  m_data,              32'h0000_000C);
        chk("fl_odd",   {31'd0, m_odd},      32'd1);
        chk("fl_done",  {31'd0, flush_done}, 32'd1);
        step();
        chk("fl_done_off", {31'd0, flush_done}, 32'd0);
        chk("fl_nv",       {31'd0, m_valid},    32'd0);
        step(); step(); step();
        chk("fl_outs",   out_cnt,             32'd8);
        chk("fl_out0",   out_data[6],         32'h000B_000A);
        chk("fl_odd0",   {31'd0, out_odd[6]}, 32'd0);
        chk("fl_out1",   out_data[7],         32'h0000_000C);
        chk("fl_odd1",   {31'd0, out_odd[7]}, 32'd1);
        chk("fl_fdcnt",  fd_cnt - fd_base,    32'd1);
        chk("fl_nopops", pop_cnt - pop_base,  32'd0);
        chk("fl_words",  {16'd0, words_out},  32'd8);

        // flush with nothing pending
        fd_base = fd_cnt;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("fe_done",  {31'd0, flush_done}, 32'd1);
        chk("fe_nv",    {31'd0, m_valid},    32'd0);
        step();
        chk("fe_done_off", {31'd0, flush_done}, 32'd0);
        chk("fe_fdcnt",    fd_cnt - fd_base,    32'd1);
        chk("fe_outs",     out_cnt,             32'd8);

        // underflow indication is sticky
        @(negedge clk);
        uf_inj = 1'b1;
        @(negedge clk);
        uf_inj = 1'b0;
        #1;
        chk("uf_set", {31'd0, err_underflow}, 32'd1);
        step(); step(); step();
        chk("uf_hold", {31'd0, err_underflow}, 32'd1);

        // asynchronous reset in the middle of traffic
        m_ready = 1'b0;
        push(16'h7001); push(16'h7002); push(16'h7003);
        for (int k = 0; k < 4; k++) step();
        chk("ar_pre_valid", {31'd0, m_valid}, 32'd1);
        chk("ar_pre_data",  m_data,           32'h7002_7001);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", {31'd0, m_valid},       32'd0);
        chk("ar_data",  m_data,                 32'd0);
        chk("ar_odd",   {31'd0, m_odd},         32'd0);
        chk("ar_err",   {31'd0, err_underflow}, 32'd0);
        chk("ar_words", {16'd0, words_out},     32'd0);
        chk("ar_rd_en", {31'd0, fifo_rd_en},    32'd0);
        chk("ar_fdone", {31'd0, flush_done},    32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
